v2dac: RTL
==========

Name: v2dac

Overview:
- Inverse of the ADC-to-voltage path: converts a signed fixed-point voltage stream into unsigned DAC codes for the DAC output channel.
- Datapath: subtract V_MIN, multiply by GAIN, round half-up, saturate to DAC range.
- Pipelined datapath with valid/ready handshake on both sides, per-sample clip flags, and sticky clip status for firmware polling.

Parameters:
- DATA_WIDTH, 32: width of the input voltage word (two's complement).
- FRACTION, 20: fractional bits of the input voltage and of GAIN.
- PIPE_WIDTH, 4: multiplier pipeline depth (mult instance).
- DAC_WIDTH, 12: output code width.
- V_MIN, 32'hFFD80000: voltage mapped to code 0 (-2.5 V).
- GAIN, 32'h33300000: codes per volt (819.0), unsigned, same fraction as the input.

Ports:
- clk, input, 1: clock.
- rst, input, 1: synchronous, active-low reset.
- voltage_ready_in, output, 1: block can accept a sample.
- voltage_valid_in, input, 1: input sample valid.
- voltage_data_in, input, DATA_WIDTH: signed voltage.
- dac_ready_out, input, 1: downstream accepts a code.
- dac_valid_out, output, 1: output code valid.
- dac_data_out, output, DAC_WIDTH: DAC code.
- dac_clip_out, output, 2: {clipped_high, clipped_low} for the current output sample.
- clip_status, output, 2: sticky {high, low} clip flags.
- clip_clear, input, 1: clears clip_status.

Behaviour:
- Reset: synchronous, active-low (rst=0 at a clk edge).
  - Outputs clear to 0: valid pipe, dac_valid_out, dac_data_out, dac_clip_out, clip_status.
  - voltage_ready_in=1 while rst=0; reset mid-stream discards every in-flight sample.
- Global enable: ce = ~dac_valid_out | dac_ready_out; voltage_ready_in = ce.
  - All datapath and valid registers advance only when ce=1.
  - When ce=0, outputs hold stable.
- Input transfer: voltage_valid_in & voltage_ready_in.
  - A bubble (valid=0 while ce=1) propagates as an invalid slot.
- Stage S0: diff = sign-extended voltage_data_in - sign-extended V_MIN, computed at DATA_WIDTH+1 bits, then registered.
- Multiplier: PIPE_WIDTH stages computing diff * GAIN.
  - GAIN is zero-extended and treated as positive.
  - Full-precision signed product, 2*DATA_WIDTH+2 bits, fraction 2*FRACTION.
- Stage S_out, registered:
  - rounded = (product + 2^(2*FRACTION-1)) >>> 2*FRACTION, arithmetic shift.
  - If rounded < 0: code = 0, clip = 2'b01.
  - Else if rounded > 2^DAC_WIDTH-1: code = all ones, clip = 2'b10.
  - Else: code = rounded, clip = 2'b00.
- Latency: PIPE_WIDTH+2 enabled cycles from input transfer to dac_valid_out (6 with defaults).
- Throughput: 1 sample/cycle with dac_ready_out held high.
- Ordering: in-order, no drop, no duplication under any backpressure pattern.
- Output transfer: dac_valid_out & dac_ready_out.
  - While dac_valid_out=1 & dac_ready_out=0: dac_data_out and dac_clip_out are stable.
- clip_status: set per bit when an output sample with that clip bit is transferred.
  - clip_clear=1 clears it at the next edge.
  - Simultaneous set and clear: set wins.
  - clip_status is not gated by ce except through the transfer condition.
- Invalid slots never affect clip_status; dac_data_out of an invalid slot is don't-care.

Test Plan:
- Rounding: voltage_data_in=32'h00000000 (0.0 V) -> dac_data_out=2048 (2047.5 rounded up), clip=00, exactly 6 cycles later with dac_ready_out=1.
- Endpoints: -2.5 V (32'hFFD80000) -> 0; +2.5 V (32'h00280000) -> 4095; both clip=00; clip_status stays 00.
- Saturation: +3.0 V (32'h00300000) -> 4095, clip=10; -3.0 V (32'hFFD00000) -> 0, clip=01; clip_status=11 afterwards; clip_clear pulse -> 00.
- Backpressure: stream 8 ramp samples back-to-back, drop dac_ready_out for 3 cycles mid-stream.
  - Expect voltage_ready_in=0 while the output is stalled.
  - Expect all 8 codes delivered in order, no duplicates, dac_data_out stable during the stall.
- Reset mid-operation: assert rst=0 with 4 samples in flight -> dac_valid_out=0 next edge, clip_status=00; after release, the first new sample emerges with 6-cycle latency and no stale data.
- Set/clear collision: clip_clear=1 in the same cycle an out-of-range sample transfers -> clip_status bit remains 1.

Source files
------------

// File: rtl/v2dac.sv
// v2dac: pipelined signed fixed-point voltage to saturated unsigned DAC code converter
module v2dac_mult #(
  parameter int A_WIDTH = 33,
  parameter int B_WIDTH = 33,
  parameter int PIPE_WIDTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              ce,
  input  logic signed [A_WIDTH-1:0]         a,
  input  logic signed [B_WIDTH-1:0]         b,
  output logic signed [A_WIDTH+B_WIDTH-1:0] p
);
  logic signed [A_WIDTH+B_WIDTH-1:0] pipe [PIPE_WIDTH];
  always_ff @(posedge clk)
    if (!rst) begin
      for (int i = 0; i < PIPE_WIDTH; i++) pipe[i] <= '0;
    end else if (ce) begin
      pipe[0] <= a * b;
      for (int i = 1; i < PIPE_WIDTH; i++) pipe[i] <= pipe[i-1];
    end
  assign p = pipe[PIPE_WIDTH-1];
endmodule

module v2dac #(
  parameter int DATA_WIDTH = 32,
  parameter int FRACTION = 20,
  parameter int PIPE_WIDTH = 4,
  parameter int DAC_WIDTH = 12,
  parameter logic [DATA_WIDTH-1:0] V_MIN = 32'hFFD80000,
  parameter logic [DATA_WIDTH-1:0] GAIN = 32'h33300000
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  voltage_ready_in,
  input  logic                  voltage_valid_in,
  input  logic [DATA_WIDTH-1:0] voltage_data_in,
  input  logic                  dac_ready_out,
  output logic                  dac_valid_out,
  output logic [DAC_WIDTH-1:0]  dac_data_out,
  output logic [1:0]            dac_clip_out,
  output logic [1:0]            clip_status,
  input  logic                  clip_clear
);
  localparam int PW = 2*DATA_WIDTH + 2;
  localparam logic signed [PW-1:0] HALF = PW'(1) << (2*FRACTION - 1);
  logic ce, v0;
  logic [PIPE_WIDTH-1:0] vp;
  logic signed [DATA_WIDTH:0] diff, diff_r, gain_ext;
  logic signed [PW-1:0] prod, biased, rounded;
  logic [DAC_WIDTH-1:0] code;
  logic [1:0] clip;
  assign ce = ~dac_valid_out | dac_ready_out;
  assign voltage_ready_in = ce | ~rst;
  assign gain_ext = {1'b0, GAIN};
  assign diff = {voltage_data_in[DATA_WIDTH-1], voltage_data_in} - {V_MIN[DATA_WIDTH-1], V_MIN};
  v2dac_mult #(.A_WIDTH(DATA_WIDTH+1), .B_WIDTH(DATA_WIDTH+1), .PIPE_WIDTH(PIPE_WIDTH)) mult (
    .clk(clk), .rst(rst), .ce(ce), .a(diff_r), .b(gain_ext), .p(prod)
  );
  always_comb begin
    biased = prod + HALF;
    rounded = biased >>> (2*FRACTION);
    clip = rounded[PW-1] ? 2'b01 : (|rounded[PW-2:DAC_WIDTH]) ? 2'b10 : 2'b00;
    code = clip[0] ? '0 : clip[1] ? '1 : rounded[DAC_WIDTH-1:0];
  end
  always_ff @(posedge clk)
    if (!rst) begin
      v0 <= 1'b0;
      vp <= '0;
      diff_r <= '0;
      dac_valid_out <= 1'b0;
      dac_data_out <= '0;
      dac_clip_out <= '0;
    end else if (ce) begin
      v0 <= voltage_valid_in;
      diff_r <= diff;
      vp <= PIPE_WIDTH'({vp, v0});
      dac_valid_out <= vp[PIPE_WIDTH-1];
      dac_data_out <= code;
      dac_clip_out <= vp[PIPE_WIDTH-1] ? clip : 2'b00;
    end
  // a new clip on the transferring sample beats a simultaneous clear
  always_ff @(posedge clk)
    if (!rst) clip_status <= '0;
    else clip_status <= (clip_clear ? 2'b00 : clip_status) | ((dac_valid_out & dac_ready_out) ? dac_clip_out : 2'b00);
endmodule
